// File: rtl/div_pkg.sv
// rtl/div_pkg.sv - shared types and default widths for the sequential 16/8 divider
package div_pkg;

    localparam int DIVIDEND_W_DEF = 16;
    localparam int DIVISOR_W_DEF  = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    function automatic int cnt_width(input int dividend_w);
        return $clog2(dividend_w);
    endfunction

endpackage

// File: rtl/div_step.sv
// rtl/div_step.sv - one combinational restoring-division step
module div_step #(
    parameter int DIVISOR_W = 8
) (
    input  logic [DIVISOR_W-1:0] rem,
    input  logic                 in_bit,
    input  logic [DIVISOR_W-1:0] divisor,
    output logic [DIVISOR_W-1:0] next_rem,
    output logic                 q_bit
);

    logic [DIVISOR_W:0] shifted;

    // The stored remainder is always below the divisor, so only the shifted trial needs the extra bit.
    always_comb begin
        shifted  = {rem, in_bit};
        q_bit    = (shifted >= {1'b0, divisor});
        next_rem = q_bit ? DIVISOR_W'(shifted - {1'b0, divisor}) : DIVISOR_W'(shifted);
    end

endmodule

// File: rtl/seq_divider_16by8.sv
// rtl/seq_divider_16by8.sv - iterative restoring divider, optional DIVIDER_CLOCK_GATE_EN datapath clock gate
module seq_divider_16by8
    import div_pkg::*;
#(
    parameter int DIVIDEND_W = DIVIDEND_W_DEF,
    parameter int DIVISOR_W  = DIVISOR_W_DEF
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DIVIDEND_W-1:0] dividend,
    input  logic [DIVISOR_W-1:0]  divisor,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DIVIDEND_W-1:0] quotient,
    output logic [DIVISOR_W-1:0]  remainder,
    output logic                  div_by_zero
);

    localparam int CNT_W = cnt_width(DIVIDEND_W);

    state_t                state;
    state_t                next_state;
    logic [DIVISOR_W-1:0]  rem;
    logic [DIVIDEND_W-1:0] q;
    logic [DIVISOR_W-1:0]  div_reg;
    logic [CNT_W-1:0]      cnt;
    logic                  dbz;
    logic                  accept;
    logic                  dp_en;
    logic                  gated_clk;
    logic [DIVISOR_W-1:0]  step_rem;
    logic                  step_q_bit;

    assign accept = in_valid && in_ready;
    assign dp_en  = (state == CALC) || accept;

`ifdef DIVIDER_CLOCK_GATE_EN
    clock_gating u_clock_gating (
        .clk       (clk),
        .en        (dp_en),
        .gated_clk (gated_clk)
    );
`else
    assign gated_clk = clk;
`endif

    div_step #(.DIVISOR_W(DIVISOR_W)) u_div_step (
        .rem      (rem),
        .in_bit   (q[DIVIDEND_W-1]),
        .divisor  (div_reg),
        .next_rem (step_rem),
        .q_bit    (step_q_bit)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (in_valid) next_state = CALC;
            CALC:    if (cnt == '0) next_state = DONE;
            DONE:    if (out_ready) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (state == IDLE);
        out_valid = (state == DONE);
    end

    // A zero divisor has its result loaded at accept and idles one CALC cycle, giving a one-cycle latency.
    always_ff @(posedge gated_clk or negedge rst_n) begin
        if (!rst_n) begin
            rem     <= '0;
            q       <= '0;
            div_reg <= '0;
            cnt     <= '0;
            dbz     <= 1'b0;
        end else if (dp_en) begin
            if (state == CALC) begin
                if (!dbz) begin
                    rem <= step_rem;
                    q   <= {q[DIVIDEND_W-2:0], step_q_bit};
                end
                cnt <= cnt - 1'b1;
            end else begin
                div_reg <= divisor;
                if (divisor == '0) begin
                    q   <= '1;
                    rem <= dividend[DIVISOR_W-1:0];
                    cnt <= '0;
                    dbz <= 1'b1;
                end else begin
                    q   <= dividend;
                    rem <= '0;
                    cnt <= CNT_W'(DIVIDEND_W - 1);
                    dbz <= 1'b0;
                end
            end
        end
    end

    assign quotient    = q;
    assign remainder   = rem;
    assign div_by_zero = dbz;

endmodule

// File: tb/tb_seq_divider_16by8.sv
// tb/tb_seq_divider_16by8.sv - self-checking bench for seq_divider_16by8
module tb_seq_divider_16by8;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] dividend = '0;
    logic [7:0]  divisor = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [15:0] quotient;
    logic [7:0]  remainder;
    logic        div_by_zero;

    int checks = 0;
    int errors = 0;

    logic        armed = 1'b0;
    logic [15:0] m_q = '0;
    logic [7:0]  m_r = '0;
    logic        m_z = 1'b0;

    seq_divider_16by8 dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .dividend    (dividend),
        .divisor     (divisor),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic logic [15:0] ref_q(input logic [15:0] a, input logic [7:0] b);
        if (b == 8'd0) return 16'hFFFF;
        return a / {8'd0, b};
    endfunction

    function automatic logic [7:0] ref_r(input logic [15:0] a, input logic [7:0] b);
        logic [15:0] r;
        if (b == 8'd0) return a[7:0];
        r = a % {8'd0, b};
        return r[7:0];
    endfunction

    always @(negedge clk) begin
        if (rst_n && out_valid) begin
            if (!armed) begin
                check("unexpected_out_valid", 32'(out_valid), 32'd0);
            end else begin
                check("quotient", 32'(quotient), 32'(m_q));
                check("remainder", 32'(remainder), 32'(m_r));
                check("div_by_zero", 32'(div_by_zero), 32'(m_z));
                check("in_ready_in_done", 32'(in_ready), 32'd0);
            end
        end
    end

    task automatic accept_op(input logic [15:0] dd, input logic [7:0] dv);
        int n;
        n = 0;
        while (!in_ready && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        check("in_ready_before_accept", 32'(in_ready), 32'd1);
        in_valid = 1'b1;
        dividend = dd;
        divisor  = dv;
        @(posedge clk); #1;
        in_valid = 1'b0;
        dividend = 16'($urandom);
        divisor  = 8'($urandom);
        m_q   = ref_q(dd, dv);
        m_r   = ref_r(dd, dv);
        m_z   = (dv == 8'd0);
        armed = 1'b1;
    endtask

    task automatic do_div(input logic [15:0] dd, input logic [7:0] dv, input int hold,
                          input logic use_lit, input logic [15:0] lit_q, input logic [7:0] lit_r,
                          input logic stuff);
        int n;
        accept_op(dd, dv);
        check("in_ready_busy", 32'(in_ready), 32'd0);
        n = 0;
        while (!out_valid && n < 40) begin
            @(posedge clk); #1;
            n++;
        end
        check("latency", 32'(n), (dv == 8'd0) ? 32'd1 : 32'd16);
        if (use_lit) begin
            check("lit_quotient", 32'(quotient), 32'(lit_q));
            check("lit_remainder", 32'(remainder), 32'(lit_r));
            check("lit_div_by_zero", 32'(div_by_zero), (dv == 8'd0) ? 32'd1 : 32'd0);
        end
        if (stuff) begin
            in_valid = 1'b1;
            dividend = 16'd100;
            divisor  = 8'd3;
        end
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            check("hold_out_valid", 32'(out_valid), 32'd1);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        armed = 1'b0;
        check("handoff_out_valid", 32'(out_valid), 32'd0);
        check("handoff_in_ready", 32'(in_ready), 32'd1);
    endtask

    initial begin
        #2;
        check("reset_in_ready", 32'(in_ready), 32'd1);
        check("reset_out_valid", 32'(out_valid), 32'd0);
        check("reset_quotient", 32'(quotient), 32'd0);
        check("reset_remainder", 32'(remainder), 32'd0);
        check("reset_div_by_zero", 32'(div_by_zero), 32'd0);

        check("model_q_200_7", 32'(ref_q(16'd200, 8'd7)), 32'd28);
        check("model_r_200_7", 32'(ref_r(16'd200, 8'd7)), 32'd4);
        check("model_q_65535_255", 32'(ref_q(16'hFFFF, 8'd255)), 32'd257);
        check("model_q_5_0", 32'(ref_q(16'd5, 8'd0)), 32'hFFFF);
        check("model_r_5_0", 32'(ref_r(16'd5, 8'd0)), 32'd5);

        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        do_div(16'd200,   8'd7,   0, 1'b1, 16'd28,    8'd4, 1'b0);
        do_div(16'hFFFF,  8'd255, 1, 1'b1, 16'd257,   8'd0, 1'b0);
        do_div(16'd3,     8'd10,  0, 1'b1, 16'd0,     8'd3, 1'b0);
        do_div(16'd5,     8'd0,   2, 1'b1, 16'hFFFF,  8'd5, 1'b0);
        do_div(16'hFFFF,  8'd1,   0, 1'b1, 16'hFFFF,  8'd0, 1'b0);
        do_div(16'd0,     8'd9,   0, 1'b1, 16'd0,     8'd0, 1'b0);

        do_div(16'd200,   8'd7,   5, 1'b1, 16'd28,    8'd4, 1'b1);
        do_div(16'd100,   8'd3,   0, 1'b1, 16'd33,    8'd1, 1'b0);

        accept_op(16'd200, 8'd7);
        repeat (7) @(posedge clk);
        #1;
        check("mid_calc_busy", 32'(in_ready), 32'd0);
        rst_n = 1'b0;
        armed = 1'b0;
        #1;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_quotient", 32'(quotient), 32'd0);
        check("rst_remainder", 32'(remainder), 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        do_div(16'd9, 8'd2, 0, 1'b1, 16'd4, 8'd1, 1'b0);

        for (int i = 0; i < 300; i++) begin
            logic [15:0] a;
            logic [7:0]  b;
            case ($urandom_range(0, 3))
                0:       a = 16'd0;
                1:       a = 16'hFFFF;
                default: a = 16'($urandom);
            endcase
            case ($urandom_range(0, 5))
                0:       b = 8'd0;
                1:       b = 8'd1;
                2:       b = 8'hFF;
                default: b = 8'($urandom);
            endcase
            do_div(a, b, $urandom_range(0, 2), 1'b0, 16'd0, 8'd0, 1'b0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
